spike_collector: RTL and testbench
==================================

Name: spike_collector

Overview:
- Downstream stage of the compute unit (cu).
- Captures the per-timestep output_spikes vector (one bit per PE) across all timesteps of one output position.
- Packs each PE's spikes into a spike train plus a spike count, and queues the finished record in a small FIFO for the writeback/memory interface.
- Applies backpressure to the cu when the FIFO cannot accept a completed record.

Parameters:
- NUM_PES, 9, number of PEs (width of the spike vector from the cu)
- MAX_TIMESTEPS, 16, maximum timesteps per record; spike train width per PE
- FIFO_DEPTH, 4, record FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  arm collector and latch num_timesteps; clears partial record
- clear  in  1  disarm, return to IDLE; FIFO contents kept
- num_timesteps  in  4  timesteps per record; 0 encodes 16
- spike_valid  in  1  cu presents the completed timestep's spikes
- output_spikes  in  NUM_PES  spike bit per PE for the current timestep
- spike_ready  out  1  collector accepts spike_valid this cycle
- out_valid  out  1  FIFO head record available
- out_ready  in  1  consumer accepts head record
- out_train  out  NUM_PES*MAX_TIMESTEPS  per-PE spike trains; PE i occupies bits [i*MAX_TIMESTEPS +: MAX_TIMESTEPS]
- out_count  out  NUM_PES*5  per-PE spike popcount; PE i occupies bits [i*5 +: 5]
- busy  out  1  state is COLLECT
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at a posedge):
  - state=IDLE, t=0.
  - Train and count accumulators cleared.
  - FIFO emptied.
  - out_valid=0, spike_ready=0, busy=0, fifo_level=0.
  - out_train and out_count read 0.
  - Reset mid-record discards the partial record and all queued records.
- States:
  - IDLE -> COLLECT on start.
  - COLLECT -> IDLE on clear.
  - start in COLLECT re-arms: t=0, accumulators cleared, new num_timesteps latched.
  - clear has priority over start when both are asserted.
- last_t = (num_timesteps_latched==0) ? 15 : num_timesteps_latched-1.
- spike_ready:
  - 0 in IDLE.
  - In COLLECT: !(t==last_t && fifo_full).
  - No same-cycle bypass: a pop at full does not raise spike_ready in that cycle.
- Accept condition: spike_valid && spike_ready && !start && !clear. A spike_valid coinciding with start or clear is ignored.
- On accept, for each PE i:
  - train[i][t] = output_spikes[i].
  - count[i] += output_spikes[i].
  - Bit t = timestep t; bits above last_t stay 0.
- End of record:
  - On accept with t==last_t: the record (updated train/count including this timestep) is pushed to the FIFO in the same cycle.
  - Accumulators clear and t returns to 0.
  - State stays COLLECT, so consecutive output positions stream without re-arming.
- On accept with t<last_t: t increments.
- FIFO:
  - out_valid = !empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; level unchanged.
  - Push on a full FIFO is impossible by construction (spike_ready gating).
  - out_train/out_count = head entry when non-empty, 0 when empty.
  - Head is stable while out_valid && !out_ready.
- Latency: the record is visible on out_* the cycle after the accepting edge of its final timestep, when the FIFO was empty.
- Counts: 5-bit, maximum 16, no saturation needed.
- busy = (state==COLLECT).

Decomposition:
- Shared package snn_pkg:
  - collector_state_t enum {IDLE, COLLECT}.
  - MAX_TIMESTEPS_DEFAULT.
  - SPK_CNT_W=5.
  - Function ts_last(num_timesteps) implementing the 0→16 encoding.
- One sub-module: spike_rec_fifo, a parameterised synchronous FIFO (width, depth) with full/empty/level and simultaneous push/pop.
- Packing and control stay in spike_collector.

Test Plan:
- Single record: rst, start with num_timesteps=3, PE0 spikes at t=0,2, PE8 at t=1, out_ready=1.
  - One record appears.
  - PE0 train=0b101, count=2.
  - PE8 train=0b010, count=1.
  - Other PEs 0.
  - fifo_level returns to 0.
- Zero encoding: num_timesteps=0, all PEs spike every timestep.
  - After 16 accepts, every train=16'hFFFF and count=16.
  - No record is produced after 15 accepts.
- Backpressure: FIFO_DEPTH=4, out_ready=0, num_timesteps=2, 5 records driven.
  - fifo_level reaches 4.
  - spike_ready=0 at t==1 of the 5th record.
  - Raise out_ready for 1 cycle: spike_ready rises the following cycle and the 5th record is pushed without data loss.
- Simultaneous push/pop: FIFO at level 2 with out_ready=1 in the final-timestep accept cycle.
  - Level stays 2.
  - Order is preserved (verified by distinct spike patterns).
- Re-arm/clear: start mid-record at t=2 (num_timesteps=4), coincident with spike_valid.
  - Spike ignored, t=0, no record pushed.
  - clear asserted together with start: state=IDLE, spike_ready=0.
- Reset mid-operation: rst with FIFO level 3 and t=1.
  - Next cycle: out_valid=0, fifo_level=0, busy=0, out_train=0.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared types, widths and timestep encoding for the spike path.
package snn_pkg;
   typedef enum logic {IDLE, COLLECT} collector_state_t;
   localparam int MAX_TIMESTEPS_DEFAULT = 16;
   localparam int SPK_CNT_W = 5;
   function automatic logic [3:0] ts_last(input logic [3:0] num_timesteps);
      return (num_timesteps == 4'd0) ? 4'd15 : num_timesteps - 4'd1;
   endfunction
endpackage

// File: rtl/spike_rec_fifo.sv
// spike_rec_fifo: synchronous record FIFO with level and simultaneous push/pop.
module spike_rec_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] level_q, level_d;
   logic do_push, do_pop;
   always_comb begin
      do_push = push_i && !full_o;
      do_pop  = pop_i && !empty_o;
      level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         level_q <= level_d;
      end
   end
   assign data_o  = mem_q[rd_q];
   assign full_o  = level_q == (AW+1)'(DEPTH);
   assign empty_o = level_q == '0;
   assign level_o = level_q;
endmodule

// File: rtl/spike_collector.sv
// spike_collector: packs per-timestep PE spikes into per-PE trains and counts,
// queuing each finished record for writeback and backpressuring the cu.
module spike_collector
   import snn_pkg::*;
#(
   parameter int NUM_PES       = 9,
   parameter int MAX_TIMESTEPS = MAX_TIMESTEPS_DEFAULT,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           clear,
   input  logic [3:0]                     num_timesteps,
   input  logic                           spike_valid,
   input  logic [NUM_PES-1:0]             output_spikes,
   output logic                           spike_ready,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_PES*MAX_TIMESTEPS-1:0] out_train,
   output logic [NUM_PES*SPK_CNT_W-1:0]   out_count,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);
   localparam int TW = NUM_PES*MAX_TIMESTEPS;
   localparam int CW = NUM_PES*SPK_CNT_W;
   collector_state_t state_q, state_d;
   logic [3:0] t_q, t_d, nts_q, nts_d, last;
   logic [TW-1:0] train_q, train_d, train_upd, head_train;
   logic [CW-1:0] count_q, count_d, count_upd, head_count;
   logic accept, push, restart, fifo_full, fifo_empty;
   always_comb begin
      last      = ts_last(nts_q);
      train_upd = train_q;
      count_upd = count_q;
      for (int i = 0; i < NUM_PES; i++) begin
         train_upd[i*MAX_TIMESTEPS + int'(t_q)] = output_spikes[i];
         count_upd[i*SPK_CNT_W +: SPK_CNT_W] = count_q[i*SPK_CNT_W +: SPK_CNT_W] + SPK_CNT_W'(output_spikes[i]);
      end
      // no bypass: the final timestep waits for a slot freed on an earlier edge
      spike_ready = (state_q == COLLECT) && !(t_q == last && fifo_full);
      accept      = spike_valid && spike_ready && !start && !clear;
      push        = accept && t_q == last;
      restart     = start || clear || push;
      state_d     = clear ? IDLE : start ? COLLECT : state_q;
      nts_d       = (start && !clear) ? num_timesteps : nts_q;
      t_d         = restart ? 4'd0 : accept ? t_q + 4'd1 : t_q;
      train_d     = restart ? '0 : accept ? train_upd : train_q;
      count_d     = restart ? '0 : accept ? count_upd : count_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         nts_q   <= '0;
         train_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         nts_q   <= nts_d;
         train_q <= train_d;
         count_q <= count_d;
      end
   end
   spike_rec_fifo #(.WIDTH(TW+CW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .data_i ({train_upd, count_upd}),
      .pop_i  (out_valid && out_ready),
      .data_o ({head_train, head_count}),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .level_o(fifo_level)
   );
   assign out_valid = !fifo_empty;
   assign out_train = fifo_empty ? '0 : head_train;
   assign out_count = fifo_empty ? '0 : head_count;
   assign busy      = state_q == COLLECT;
endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: randomized and directed checks of spike_collector against
// a record-level model (queue of finished records, trains built by bit placement).
module tb_spike_collector;
   localparam int NP = 9;
   localparam int MT = 16;
   localparam int FD = 4;
   localparam int SW = 6 + NP*MT + NP*5;
   logic clk = 1'b0;
   logic rst, start, clear, spike_valid, spike_ready, out_valid, out_ready, busy;
   logic [3:0] num_timesteps;
   logic [NP-1:0] output_spikes;
   logic [NP*MT-1:0] out_train;
   logic [NP*5-1:0] out_count;
   logic [2:0] fifo_level;
   logic [SW-1:0] dut_snap;
   typedef struct {
      logic [NP*MT-1:0] train;
      logic [NP*5-1:0]  count;
   } rec_t;
   rec_t q[$];
   logic [NP*MT-1:0] cur;
   int cur_n, n_ts, n_vec, n_err;
   bit armed;

   spike_collector #(.NUM_PES(NP), .MAX_TIMESTEPS(MT), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .num_timesteps(num_timesteps),
      .spike_valid(spike_valid), .output_spikes(output_spikes), .spike_ready(spike_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_train(out_train), .out_count(out_count),
      .busy(busy), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;
   assign dut_snap = {spike_ready, out_valid, busy, fifo_level, out_train, out_count};

   function automatic rec_t finish_rec(input logic [NP*MT-1:0] tr);
      rec_t r;
      r.train = tr;
      for (int i = 0; i < NP; i++) r.count[i*5 +: 5] = 5'($countones(tr[i*MT +: MT]));
      return r;
   endfunction

   function automatic bit m_ready();
      return armed && !(cur_n == n_ts - 1 && q.size() == FD);
   endfunction

   function automatic logic [SW-1:0] m_snap();
      logic [NP*MT-1:0] tr;
      logic [NP*5-1:0] ct;
      tr = (q.size() != 0) ? q[0].train : '0;
      ct = (q.size() != 0) ? q[0].count : '0;
      return {m_ready(), q.size() != 0, armed, 3'(q.size()), tr, ct};
   endfunction

   task automatic step(input logic st, input logic cl, input logic [3:0] nts, input logic sv,
                       input logic [NP-1:0] spk, input logic ordy);
      bit rdy, pop;
      @(negedge clk);
      rst = 1'b0; start = st; clear = cl; num_timesteps = nts;
      spike_valid = sv; output_spikes = spk; out_ready = ordy;
      rdy = m_ready();
      pop = q.size() != 0 && ordy;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (cl) begin
         armed = 0; cur = '0; cur_n = 0;
      end else if (st) begin
         armed = 1; n_ts = (nts == 4'd0) ? 16 : int'(nts); cur = '0; cur_n = 0;
      end else if (sv && rdy) begin
         for (int i = 0; i < NP; i++) cur[i*MT + cur_n] = spk[i];
         cur_n++;
         if (cur_n == n_ts) begin
            q.push_back(finish_rec(cur));
            cur = '0; cur_n = 0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 0; clear = 0; spike_valid = 0; out_ready = 0;
      output_spikes = '0; num_timesteps = '0;
      @(posedge clk);
      q.delete(); armed = 0; cur = '0; cur_n = 0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      do_reset();
      n_vec++;
      if ({out_valid, spike_ready, busy, fifo_level} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags got %b exp 000000", {out_valid, spike_ready, busy, fifo_level});
      end
      n_vec++;
      if ({out_train, out_count} !== '0) begin
         n_err++; $display("FAIL reset_data got %h exp 0", {out_train, out_count});
      end
   endtask

   task automatic test_single_record();
      logic [NP*MT-1:0] et;
      logic [NP*5-1:0] ec;
      et = '0; et[15:0] = 16'h0005; et[8*MT +: 16] = 16'h0002;
      ec = '0; ec[4:0] = 5'd2; ec[40 +: 5] = 5'd1;
      step(1, 0, 4'd3, 0, '0, 1);
      step(0, 0, 4'd0, 1, 9'h001, 1);
      step(0, 0, 4'd0, 1, 9'h100, 1);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL single_early got out_valid=%b exp 0", out_valid);
      end
      step(0, 0, 4'd0, 1, 9'h001, 1);
      n_vec++;
      if ({out_valid, out_train, out_count} !== {1'b1, et, ec}) begin
         n_err++; $display("FAIL single_record got %b/%h/%h exp 1/%h/%h", out_valid, out_train, out_count, et, ec);
      end
      n_vec++;
      if (dut_snap !== m_snap()) begin
         n_err++; $display("FAIL single_model got %h exp %h", dut_snap, m_snap());
      end
      step(0, 0, 4'd0, 0, '0, 1);
      n_vec++;
      if (fifo_level !== 3'd0) begin
         n_err++; $display("FAIL single_drain got level=%0d exp 0", fifo_level);
      end
   endtask

   task automatic test_zero_encoding();
      step(1, 0, 4'd0, 0, '0, 0);
      for (int k = 0; k < 15; k++) step(0, 0, 4'd0, 1, '1, 0);
      n_vec++;
      if ({out_valid, busy, spike_ready} !== 3'b011) begin
         n_err++; $display("FAIL zero_after15 got %b exp 011", {out_valid, busy, spike_ready});
      end
      step(0, 0, 4'd0, 1, '1, 0);
      n_vec++;
      if ({out_valid, out_train, out_count} !== {1'b1, {(NP*MT){1'b1}}, {NP{5'd16}}}) begin
         n_err++; $display("FAIL zero_record got %b/%h/%h exp all-ones/16", out_valid, out_train, out_count);
      end
      step(0, 0, 4'd0, 0, '0, 1);
      n_vec++;
      if (dut_snap !== m_snap()) begin
         n_err++; $display("FAIL zero_drain got %h exp %h", dut_snap, m_snap());
      end
   endtask

   task automatic test_backpressure();
      step(1, 0, 4'd2, 0, '0, 0);
      for (int r = 0; r < 4; r++) begin
         step(0, 0, 4'd0, 1, 9'(r*37 + 1), 0);
         step(0, 0, 4'd0, 1, 9'(r*11 + 5), 0);
      end
      n_vec++;
      if (fifo_level !== 3'd4) begin
         n_err++; $display("FAIL bp_full got level=%0d exp 4", fifo_level);
      end
      step(0, 0, 4'd0, 1, 9'h1A5, 0);
      n_vec++;
      if (spike_ready !== 1'b0) begin
         n_err++; $display("FAIL bp_stall got spike_ready=%b exp 0", spike_ready);
      end
      step(0, 0, 4'd0, 1, 9'h0FF, 0);
      n_vec++;
      if ({spike_ready, fifo_level} !== {1'b0, 3'd4}) begin
         n_err++; $display("FAIL bp_hold got %b exp 0100", {spike_ready, fifo_level});
      end
      step(0, 0, 4'd0, 0, '0, 1);
      n_vec++;
      if ({spike_ready, fifo_level} !== {1'b1, 3'd3}) begin
         n_err++; $display("FAIL bp_release got %b exp 1011", {spike_ready, fifo_level});
      end
      step(0, 0, 4'd0, 1, 9'h05A, 0);
      n_vec++;
      if (dut_snap !== m_snap()) begin
         n_err++; $display("FAIL bp_push got %h exp %h", dut_snap, m_snap());
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 4'd0, 0, '0, 1);
         n_vec++;
         if (dut_snap !== m_snap()) begin
            n_err++; $display("FAIL bp_drain%0d got %h exp %h", k, dut_snap, m_snap());
         end
      end
   endtask

   task automatic test_push_pop();
      step(1, 0, 4'd2, 0, '0, 0);
      for (int r = 0; r < 3; r++) begin
         step(0, 0, 4'd0, 1, 9'(r*73 + 3), 0);
         step(0, 0, 4'd0, 1, 9'(r*29 + 2), r == 2);
      end
      n_vec++;
      if (fifo_level !== 3'd2) begin
         n_err++; $display("FAIL pp_level got level=%0d exp 2", fifo_level);
      end
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (dut_snap !== m_snap()) begin
            n_err++; $display("FAIL pp_order%0d got %h exp %h", k, dut_snap, m_snap());
         end
         step(0, 0, 4'd0, 0, '0, 1);
      end
   endtask

   task automatic test_rearm_clear();
      step(1, 0, 4'd4, 0, '0, 0);
      step(0, 0, 4'd0, 1, 9'h1FF, 0);
      step(0, 0, 4'd0, 1, 9'h1FF, 0);
      step(1, 0, 4'd4, 1, 9'h1FF, 0);
      n_vec++;
      if ({busy, out_valid, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
         n_err++; $display("FAIL rearm_state got %b exp 10000", {busy, out_valid, fifo_level});
      end
      for (int k = 0; k < 3; k++) step(0, 0, 4'd0, 1, 9'h001, 0);
      n_vec++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL rearm_early got out_valid=%b exp 0", out_valid);
      end
      step(0, 0, 4'd0, 1, 9'h002, 0);
      n_vec++;
      if ({out_valid, out_train[15:0], out_train[31:16]} !== {1'b1, 16'h0007, 16'h0008}) begin
         n_err++; $display("FAIL rearm_record got %b/%h/%h exp 1/0007/0008", out_valid, out_train[15:0], out_train[31:16]);
      end
      step(1, 1, 4'd3, 1, 9'h1FF, 0);
      n_vec++;
      if ({busy, spike_ready} !== 2'b00) begin
         n_err++; $display("FAIL clear_prio got %b exp 00", {busy, spike_ready});
      end
      step(0, 0, 4'd0, 0, '0, 1);
      n_vec++;
      if (dut_snap !== m_snap()) begin
         n_err++; $display("FAIL clear_model got %h exp %h", dut_snap, m_snap());
      end
   endtask

   task automatic test_reset_mid();
      step(1, 0, 4'd2, 0, '0, 0);
      for (int k = 0; k < 7; k++) step(0, 0, 4'd0, 1, 9'(k*53 + 7), 0);
      n_vec++;
      if (fifo_level !== 3'd3) begin
         n_err++; $display("FAIL rmid_level got level=%0d exp 3", fifo_level);
      end
      do_reset();
      n_vec++;
      if ({out_valid, busy, fifo_level, out_train} !== '0) begin
         n_err++; $display("FAIL rmid_clear got %b/%b/%0d/%h exp all 0", out_valid, busy, fifo_level, out_train);
      end
   endtask

   task automatic test_random();
      step(1, 0, 4'($urandom_range(0, 15)), 0, '0, 0);
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 79) == 0, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 3) == 0);
         n_vec++;
         if (dut_snap !== m_snap()) begin
            n_err++; $display("FAIL random%0d got %h exp %h", k, dut_snap, m_snap());
         end
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; armed = 0; cur = '0; cur_n = 0; n_ts = 16;
      test_reset();
      test_single_record();
      test_zero_encoding();
      test_backpressure();
      test_push_pop();
      test_rearm_clear();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
